// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller's user read/write port
// between NumPorts requesters, with a per-transaction completion watchdog.
module sdram_port_arbiter #(
  parameter int NumPorts      = 2,
  parameter int AddrWidth     = 22,
  parameter int DataWidth     = 16,
  parameter int TimeoutCycles = 4096
) (
  input  logic                           i_dram_clk,
  input  logic                           i_rst_n,
  input  logic [NumPorts-1:0]            i_req,
  input  logic [NumPorts-1:0]            i_we,
  input  logic [NumPorts*AddrWidth-1:0]  i_addr,
  input  logic [NumPorts*DataWidth-1:0]  i_wr_data,
  output logic [NumPorts-1:0]            o_ack,
  output logic [NumPorts-1:0]            o_rd_valid,
  output logic [DataWidth-1:0]           o_rd_data,
  output logic                           o_err,
  output logic                           o_busy,
  output logic                           o_ctrl_wr_req,
  output logic                           o_ctrl_rd_req,
  output logic [AddrWidth-1:0]           o_ctrl_addr,
  output logic [DataWidth-1:0]           o_ctrl_wr_data,
  input  logic                           i_ctrl_wr_done,
  input  logic                           i_ctrl_rd_rdy,
  input  logic [DataWidth-1:0]           i_ctrl_rd_data
);

  localparam int PortIdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int CntWidth     = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, DONE} state_e;

  state_e                  state_q, state_d;
  // The round-robin pointer always equals the last grant, so it also selects the ack target.
  logic [PortIdxWidth-1:0] ptr_q, ptr_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic [DataWidth-1:0]    wr_data_q, wr_data_d;
  logic [DataWidth-1:0]    rd_data_q, rd_data_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic                    rd_flag_q, rd_flag_d;
  logic                    err_flag_q, err_flag_d;

  logic                    found;
  logic [PortIdxWidth-1:0] win;
  logic [PortIdxWidth-1:0] idx;
  logic                    timeout;

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop samples the values from before the edge, independent of process order.
  always_ff @(posedge i_dram_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= PortIdxWidth'(NumPorts - 1);
      addr_q     <= '0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      cnt_q      <= '0;
      rd_flag_q  <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= rd_data_d;
      cnt_q      <= cnt_d;
      rd_flag_q  <= rd_flag_d;
      err_flag_q <= err_flag_d;
    end
  end

  // NOTE: every signal assigned in a combinational block gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    rd_data_d  = rd_data_q;
    cnt_d      = cnt_q;
    rd_flag_d  = rd_flag_q;
    err_flag_d = err_flag_q;
    found      = 1'b0;
    win        = ptr_q;
    idx        = ptr_q;
    timeout    = (cnt_q == CntWidth'(TimeoutCycles - 1));

    // Search starts one past the last winner so each port waits at most NumPorts-1 grants.
    for (int i = 1; i <= NumPorts; i++) begin
      idx = PortIdxWidth'((int'(ptr_q) + i) % NumPorts);
      if (!found && i_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          ptr_d      = win;
          addr_d     = i_addr[int'(win)*AddrWidth +: AddrWidth];
          wr_data_d  = i_wr_data[int'(win)*DataWidth +: DataWidth];
          cnt_d      = '0;
          rd_flag_d  = 1'b0;
          err_flag_d = 1'b0;
          state_d    = i_we[win] ? WR_WAIT : RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (i_ctrl_wr_done) begin
          state_d = DONE;
        end else if (timeout) begin
          err_flag_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_WAIT: begin
        if (i_ctrl_rd_rdy) begin
          rd_data_d = i_ctrl_rd_data;
          rd_flag_d = 1'b1;
          state_d   = DONE;
        end else if (timeout) begin
          err_flag_d = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        rd_flag_d  = 1'b0;
        err_flag_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ack      = '0;
    o_rd_valid = '0;
    o_err      = 1'b0;
    if (state_q == DONE) begin
      o_ack[ptr_q]      = 1'b1;
      o_rd_valid[ptr_q] = rd_flag_q;
      o_err             = err_flag_q;
    end
  end

  assign o_busy         = (state_q != IDLE);
  assign o_ctrl_wr_req  = (state_q == WR_WAIT);
  assign o_ctrl_rd_req  = (state_q == RD_WAIT);
  assign o_ctrl_addr    = addr_q;
  assign o_ctrl_wr_data = wr_data_q;
  assign o_rd_data      = rd_data_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a table of single transactions plus
// hand-written round-robin and mid-transaction reset sequences.
module tb_sdram_port_arbiter;

  localparam int NP = 2;
  localparam int AW = 22;
  localparam int DW = 16;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    i_req;
  logic [NP-1:0]    i_we;
  logic [NP*AW-1:0] i_addr;
  logic [NP*DW-1:0] i_wr_data;
  logic [NP-1:0]    o_ack;
  logic [NP-1:0]    o_rd_valid;
  logic [DW-1:0]    o_rd_data;
  logic             o_err;
  logic             o_busy;
  logic             o_ctrl_wr_req;
  logic             o_ctrl_rd_req;
  logic [AW-1:0]    o_ctrl_addr;
  logic [DW-1:0]    o_ctrl_wr_data;
  logic             i_ctrl_wr_done;
  logic             i_ctrl_rd_rdy;
  logic [DW-1:0]    i_ctrl_rd_data;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .i_dram_clk(clk), .i_rst_n(rst_n),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wr_data(i_wr_data),
    .o_ack(o_ack), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_err(o_err), .o_busy(o_busy),
    .o_ctrl_wr_req(o_ctrl_wr_req), .o_ctrl_rd_req(o_ctrl_rd_req),
    .o_ctrl_addr(o_ctrl_addr), .o_ctrl_wr_data(o_ctrl_wr_data),
    .i_ctrl_wr_done(i_ctrl_wr_done), .i_ctrl_rd_rdy(i_ctrl_rd_rdy),
    .i_ctrl_rd_data(i_ctrl_rd_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;    // value the controller returns on a read
    int            delay;    // completion sampled on this wait cycle (1-based); 0 = never
    logic          stray;    // wrong-kind completion pulse on the second wait cycle
    int            exp_req;  // cycles the controller request is high
    logic          exp_rv;
    logic          exp_err;
    logic [DW-1:0] exp_rd;   // o_rd_data after the transaction
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input int k);
    int            cyc;
    int            req_cyc;
    logic [NP-1:0] exp_ack;
    logic [NP-1:0] exp_rv;
    exp_ack = '0;
    exp_ack[v.port] = 1'b1;
    exp_rv = '0;
    exp_rv[v.port] = v.exp_rv;
    i_we[v.port] = v.we;
    i_addr[v.port*AW +: AW] = v.addr;
    i_wr_data[v.port*DW +: DW] = v.wdata;
    i_req = exp_ack;
    @(negedge clk);
    cyc = 0;
    req_cyc = 0;
    while (o_ack == '0 && cyc < 64) begin
      if (cyc == 0) begin
        check($sformatf("v%0d wr_req", k), o_ctrl_wr_req, v.we);
        check($sformatf("v%0d rd_req", k), o_ctrl_rd_req, !v.we);
        check($sformatf("v%0d ctrl_addr", k), o_ctrl_addr, v.addr);
        check($sformatf("v%0d busy", k), o_busy, 1'b1);
        if (v.we) check($sformatf("v%0d ctrl_wr_data", k), o_ctrl_wr_data, v.wdata);
      end
      if (o_ctrl_wr_req || o_ctrl_rd_req) req_cyc++;
      i_ctrl_wr_done = 1'b0;
      i_ctrl_rd_rdy  = 1'b0;
      i_ctrl_rd_data = 16'hDEAD;
      if (v.delay != 0 && cyc == v.delay - 1) begin
        if (v.we) i_ctrl_wr_done = 1'b1;
        else begin
          i_ctrl_rd_rdy  = 1'b1;
          i_ctrl_rd_data = v.rdata;
        end
      end else if (v.stray && cyc == 1) begin
        if (v.we) i_ctrl_rd_rdy = 1'b1;
        else i_ctrl_wr_done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    i_ctrl_wr_done = 1'b0;
    i_ctrl_rd_rdy  = 1'b0;
    check($sformatf("v%0d ack", k), o_ack, exp_ack);
    check($sformatf("v%0d rd_valid", k), o_rd_valid, exp_rv);
    check($sformatf("v%0d err", k), o_err, v.exp_err);
    check($sformatf("v%0d req_cycles", k), req_cyc, v.exp_req);
    i_req = '0;
    @(negedge clk);
    check($sformatf("v%0d ack_one_cycle", k), o_ack, '0);
    check($sformatf("v%0d idle_busy", k), o_busy, 1'b0);
    check($sformatf("v%0d rd_data", k), o_rd_data, v.exp_rd);
  endtask

  logic [NP-1:0] order[4];
  int            n_ack;
  int            both_high;
  int            busy_bad;
  int            cyc;

  initial begin
    vecs[0] = '{0, 1'b1, 22'h012345, 16'hBEEF, 16'h0000,  5, 1'b0,  5, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1, 1'b0, 22'h000A5A, 16'h0000, 16'h1234,  3, 1'b0,  3, 1'b1, 1'b0, 16'h1234};
    vecs[2] = '{0, 1'b1, 22'h3FFFFF, 16'h0001, 16'h0000,  1, 1'b0,  1, 1'b0, 1'b0, 16'h1234};
    vecs[3] = '{1, 1'b0, 22'h000100, 16'h0000, 16'h7777,  0, 1'b0, 16, 1'b0, 1'b1, 16'h1234};
    vecs[4] = '{0, 1'b1, 22'h2AAAAA, 16'h5555, 16'h0000,  4, 1'b1,  4, 1'b0, 1'b0, 16'h1234};
    vecs[5] = '{1, 1'b0, 22'h155555, 16'h0000, 16'hCAFE, 16, 1'b0, 16, 1'b1, 1'b0, 16'hCAFE};
    vecs[6] = '{0, 1'b1, 22'h000001, 16'hFFFF, 16'h0000,  0, 1'b0, 16, 1'b0, 1'b1, 16'hCAFE};
    vecs[7] = '{1, 1'b0, 22'h0ABCDE, 16'h0000, 16'h0F0F,  3, 1'b1,  3, 1'b1, 1'b0, 16'h0F0F};

    rst_n = 1'b0;
    i_req = '0;
    i_we = '0;
    i_addr = '0;
    i_wr_data = '0;
    i_ctrl_wr_done = 1'b0;
    i_ctrl_rd_rdy = 1'b0;
    i_ctrl_rd_data = 16'hDEAD;
    #3;
    check("rst busy", o_busy, 1'b0);
    check("rst ack", o_ack, '0);
    check("rst ctrl_reqs", {o_ctrl_wr_req, o_ctrl_rd_req}, 2'b00);
    check("rst rd_data", o_rd_data, '0);
    check("rst ctrl_addr", o_ctrl_addr, '0);
    check("rst err", o_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

    // Both ports requesting continuously from reset: port 0 writes, port 1 reads.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    i_we = 2'b01;
    i_addr[0*AW +: AW] = 22'h000111;
    i_addr[1*AW +: AW] = 22'h000222;
    i_req = 2'b11;
    n_ack = 0;
    both_high = 0;
    busy_bad = 0;
    cyc = 0;
    while (n_ack < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (o_ctrl_wr_req && o_ctrl_rd_req) both_high++;
      if (o_busy !== (o_ctrl_wr_req || o_ctrl_rd_req || o_ack != '0)) busy_bad++;
      if (o_ack != '0) begin
        order[n_ack] = o_ack;
        n_ack++;
      end
      i_req = ~o_ack;
      i_ctrl_wr_done = o_ctrl_wr_req;
      i_ctrl_rd_rdy = o_ctrl_rd_req;
      i_ctrl_rd_data = 16'h5A5A;
    end
    i_req = '0;
    i_ctrl_wr_done = 1'b0;
    i_ctrl_rd_rdy = 1'b0;
    check("rr ack_count", n_ack, 4);
    check("rr grant0", order[0], 2'b01);
    check("rr grant1", order[1], 2'b10);
    check("rr grant2", order[2], 2'b01);
    check("rr grant3", order[3], 2'b10);
    check("rr both_reqs_high", both_high, 0);
    check("rr busy_outside_idle", busy_bad, 0);
    @(negedge clk);
    check("rr rd_data", o_rd_data, 16'h5A5A);

    // Reset asserted while a read from port 1 is waiting on the controller.
    i_req = 2'b10;
    @(negedge clk);
    @(negedge clk);
    check("mid rd_req_before", o_ctrl_rd_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid rd_req", o_ctrl_rd_req, 1'b0);
    check("mid busy", o_busy, 1'b0);
    check("mid ack", o_ack, '0);
    check("mid rd_data", o_rd_data, '0);
    i_req = 2'b11;
    @(negedge clk);
    check("mid held_idle", o_busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post wr_req", o_ctrl_wr_req, 1'b1);
    check("post ctrl_addr", o_ctrl_addr, 22'h000111);
    i_ctrl_wr_done = 1'b1;
    @(negedge clk);
    i_ctrl_wr_done = 1'b0;
    check("post ack", o_ack, 2'b01);
    i_req = '0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single user-side read/write interface of the SDRAM controller between NumPorts independent requesters, using round-robin arbitration.
- Each transaction is granted, latched and presented to the controller. The block waits for controller completion, then returns a one-cycle acknowledge (plus read data for reads) to the owning port.
- Sits between the client blocks and the SDRAM controller in the i_dram_clk domain.
- A watchdog aborts a transaction the controller never completes.

Parameters:
NumPorts, 2, number of requesters (>=2)
AddrWidth, 22, user address width {bank, col, row}
DataWidth, 16, data word width
TimeoutCycles, 4096, max cycles in a wait state before abort
PortIdxWidth, $clog2(NumPorts), localparam, grant index width

Ports:
i_dram_clk  in  1  clock; all logic rises on posedge
i_rst_n  in  1  asynchronous active-low reset
i_req  in  NumPorts  per-port request; held until o_ack seen
i_we  in  NumPorts  per-port 1=write, 0=read; stable while i_req high
i_addr  in  NumPorts*AddrWidth  per-port address, port p at [p*AddrWidth +: AddrWidth]
i_wr_data  in  NumPorts*DataWidth  per-port write data, same packing
o_ack  out  NumPorts  one-cycle completion pulse to the owning port
o_rd_valid  out  NumPorts  one-cycle pulse, coincident with o_ack, on read completion
o_rd_data  out  DataWidth  registered read data, shared by all ports
o_err  out  1  one-cycle pulse, coincident with o_ack, on watchdog abort
o_busy  out  1  high in any state except IDLE
o_ctrl_wr_req  out  1  write request to controller
o_ctrl_rd_req  out  1  read request to controller
o_ctrl_addr  out  AddrWidth  latched address to controller
o_ctrl_wr_data  out  DataWidth  latched write data to controller
i_ctrl_wr_done  in  1  controller pulse: WRITE command issued
i_ctrl_rd_rdy  in  1  controller pulse: read data valid this cycle
i_ctrl_rd_data  in  DataWidth  controller read data

Behaviour:
- Reset (async, any state): state=IDLE, ptr=NumPorts-1, counter=0. All outputs 0, including o_ctrl_* and o_rd_data. An in-flight transaction is dropped with no ack; the controller request drops immediately.
- States: IDLE, WR_WAIT, RD_WAIT, DONE. o_ctrl_wr_req = (state==WR_WAIT); o_ctrl_rd_req = (state==RD_WAIT). Both are Moore outputs, never high together.
- IDLE:
  - Search ports ptr+1, ptr+2, ... modulo NumPorts; first with i_req high wins.
  - On a win, register: grant=p, ptr=p, addr, wr_data, we. Counter cleared.
  - Next state = WR_WAIT if we, else RD_WAIT. No request: stay in IDLE.
- Latched addr/data drive o_ctrl_addr/o_ctrl_wr_data from the cycle after grant until the next grant. Requester inputs are ignored after the grant.
- WR_WAIT:
  - i_ctrl_wr_done -> DONE.
  - Else counter==TimeoutCycles-1 -> DONE with err flag set.
  - Else counter++.
- RD_WAIT:
  - i_ctrl_rd_rdy -> o_rd_data <= i_ctrl_rd_data, rd flag set, -> DONE.
  - Same timeout rule as WR_WAIT. On timeout o_rd_data is unchanged and o_rd_valid stays 0.
- DONE (exactly one cycle):
  - o_ack[grant]=1; o_rd_valid[grant]=rd flag; o_err=err flag; then IDLE.
  - Flags clear on leaving DONE.
- Requester drops i_req in the cycle after o_ack. The IDLE cycle following DONE therefore cannot re-grant the same transaction.
- Minimum spacing: grant-to-grant is 3 cycles (IDLE, WAIT, DONE).
- Completion pulse in the wrong wait state (wr_done in RD_WAIT, rd_rdy in WR_WAIT, either in IDLE/DONE) is ignored.
- Completion and timeout in the same cycle: completion wins, no error.
- o_rd_data holds its value until the next successful read.
- Fairness: a continuously requesting port waits at most NumPorts-1 other transactions.

Test Plan:
- Single write, port 0, addr 0x12345, data 0xBEEF; wr_done 5 cycles after o_ctrl_wr_req rises -> o_ctrl_addr=0x12345, o_ctrl_wr_data=0xBEEF during WR_WAIT; o_ack=2'b01 exactly one cycle, one cycle after wr_done; o_rd_valid=0, o_err=0.
- Single read, port 1, addr 0x00A5A; controller returns 0x1234 with rd_rdy -> next cycle o_ack=2'b10, o_rd_valid=2'b10, o_rd_data=0x1234, held through subsequent writes.
- Both ports requesting continuously from reset, 4 transactions -> grant order 0,1,0,1; o_ctrl_wr_req and o_ctrl_rd_req never high together; o_busy low only in IDLE cycles.
- TimeoutCycles=16, read with no rd_rdy -> o_ctrl_rd_req high exactly 16 cycles; then o_ack and o_err pulse together, o_rd_valid=0, o_rd_data unchanged.
- Stray i_ctrl_rd_rdy during WR_WAIT, then wr_done -> stray ignored; single o_ack with o_rd_valid=0.
- Assert i_rst_n low mid RD_WAIT -> o_ctrl_rd_req, o_busy, o_ack, o_rd_data are 0 immediately (before next edge); after release, port 0 wins the first grant when both request.
